// File: rtl/instruction_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register for the MIPS core.
// Handles the PC, the ready/valid request to instruction memory, stall and redirect/flush.
module instruction_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  input  logic        JR,
  input  logic [31:0] JRTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemRData,
  input  logic        IMemReady,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic [5:0]  OP
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] skid_q;
  logic [31:0] tgt_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;
  logic        pend_q;

  logic        redir;
  logic [31:0] redir_tgt;
  logic [31:0] pc_inc;
  logic        req;
  logic        fire;
  logic        unused_bits;

  always_comb begin
    redir = JR | Jump | BranchTaken;
    if (JR)
      redir_tgt = {JRTarget[31:2], 2'b00};
    else if (Jump)
      redir_tgt = {pc4_q[31:28], JumpIndex, 2'b00};
    else
      redir_tgt = {BranchTarget[31:2], 2'b00};
    pc_inc = pc_q + 32'd4;
    // Gated by reset so an outstanding request is abandoned the instant reset asserts.
    req  = reset & ((state_q == DRAIN) | ((state_q == FETCH) & (~Stall | pend_q)));
    fire = req & IMemReady;
  end

  assign unused_bits = ^{BranchTarget[1:0], JRTarget[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= PC_RESET;
      skid_q  <= '0;
      tgt_q   <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (redir) begin
            instr_q <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            // An unanswered request must finish at its old address before the PC moves.
            if (req && !IMemReady) begin
              tgt_q   <= redir_tgt;
              state_q <= DRAIN;
            end else begin
              pc_q <= redir_tgt;
            end
          end else if (fire) begin
            pend_q <= 1'b0;
            pc_q   <= pc_inc;
            if (Stall) begin
              skid_q  <= IMemRData;
              state_q <= HOLD;
            end else begin
              instr_q <= IMemRData;
              pc4_q   <= pc_inc;
              valid_q <= 1'b1;
            end
          end else begin
            pend_q <= req;
            if (!Stall) begin
              instr_q <= '0;
              valid_q <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (redir) begin
            instr_q <= '0;
            valid_q <= 1'b0;
            pc_q    <= redir_tgt;
            state_q <= FETCH;
          end else if (!Stall) begin
            instr_q <= skid_q;
            pc4_q   <= pc_q;
            valid_q <= 1'b1;
            state_q <= FETCH;
          end
        end
        DRAIN: begin
          if (redir) begin
            instr_q <= '0;
            valid_q <= 1'b0;
          end
          if (IMemReady) begin
            pc_q    <= redir ? redir_tgt : tgt_q;
            state_q <= FETCH;
          end else if (redir) begin
            tgt_q <= redir_tgt;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign IMemReq      = req;
  assign IMemAddr     = pc_q;
  assign IFID_Instr   = instr_q;
  assign IFID_PCPlus4 = pc4_q;
  assign IFID_Valid   = valid_q;
  assign OP           = instr_q[31:26];

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed timing checks, then randomized stall/ready/redirect
// traffic checked against a program-order reference model.
module tb_instruction_fetch;

  localparam logic [31:0] PC_RESET = 32'h0040_0000;

  logic        clk;
  logic        reset;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [25:0] JumpIndex;
  logic        JR;
  logic [31:0] JRTarget;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] IMemRData;
  logic        IMemReady;
  logic [31:0] IFID_Instr;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic [5:0]  OP;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: next program-order address, last delivered PC+4, pending request.
  logic [31:0] exp_next;
  logic [31:0] m_pc4;
  logic        pend;
  logic [31:0] pend_addr;
  int          idle;
  logic [31:0] snap;

  instruction_fetch #(.PC_RESET(PC_RESET)) dut (
    .clk(clk), .reset(reset), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpIndex(JumpIndex), .JR(JR), .JRTarget(JRTarget),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemRData(IMemRData), .IMemReady(IMemReady),
    .IFID_Instr(IFID_Instr), .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid), .OP(OP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[7:2], a[27:2]} ^ 32'h0000_5A5A;
  endfunction

  assign IMemRData = memw(IMemAddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_redirect();
    BranchTaken = 1'b0;
    Jump        = 1'b0;
    JR          = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(IMemReq), 0);
    chk({tag, "_addr"},  IMemAddr, PC_RESET);
    chk({tag, "_instr"}, IFID_Instr, 0);
    chk({tag, "_pc4"},   IFID_PCPlus4, 0);
    chk({tag, "_valid"}, 32'(IFID_Valid), 0);
    chk({tag, "_op"},    32'(OP), 0);
  endtask

  // Applies the inputs already driven for one clock and checks the result against the model.
  task automatic cycle();
    logic [31:0] tgt;
    logic [31:0] w;
    logic [31:0] s_instr;
    logic [31:0] s_pc4;
    logic        s_valid;
    logic        rd;
    logic        st;
    logic        nxt_pend;
    logic [31:0] nxt_addr;
    #1;
    if (pend) begin
      chk("req_held", 32'(IMemReq), 1);
      chk("addr_held", IMemAddr, pend_addr);
    end else begin
      if (Stall) chk("req_under_stall", 32'(IMemReq), 0);
      if (IMemReq) chk("fetch_addr", IMemAddr, exp_next);
    end
    rd = JR | Jump | BranchTaken;
    if (JR)        tgt = {JRTarget[31:2], 2'b00};
    else if (Jump) tgt = {m_pc4[31:28], JumpIndex, 2'b00};
    else           tgt = {BranchTarget[31:2], 2'b00};
    st       = Stall;
    s_instr  = IFID_Instr;
    s_pc4    = IFID_PCPlus4;
    s_valid  = IFID_Valid;
    nxt_pend = IMemReq & ~IMemReady;
    nxt_addr = IMemAddr;
    @(posedge clk);
    pend      = nxt_pend;
    pend_addr = nxt_addr;
    @(negedge clk);
    if (rd) begin
      chk("flush_valid", 32'(IFID_Valid), 0);
      chk("flush_instr", IFID_Instr, 0);
      chk("flush_pc4", IFID_PCPlus4, s_pc4);
      exp_next = tgt;
      idle = 0;
    end else if (st) begin
      chk("stall_instr", IFID_Instr, s_instr);
      chk("stall_pc4", IFID_PCPlus4, s_pc4);
      chk("stall_valid", 32'(IFID_Valid), 32'(s_valid));
      idle = 0;
    end else if (IFID_Valid) begin
      w = memw(exp_next);
      chk("seq_pc4", IFID_PCPlus4, exp_next + 32'd4);
      chk("seq_instr", IFID_Instr, w);
      chk("seq_op", 32'(OP), 32'(w[31:26]));
      m_pc4    = exp_next + 32'd4;
      exp_next = exp_next + 32'd4;
      idle = 0;
    end else begin
      idle++;
    end
    chk("progress", 32'(idle > 40), 0);
  endtask

  initial begin
    reset = 1'b0;
    Stall = 1'b0;
    clr_redirect();
    BranchTarget = '0;
    JumpIndex    = '0;
    JRTarget     = '0;
    IMemReady    = 1'b1;
    exp_next = PC_RESET;
    m_pc4    = '0;
    pend     = 1'b0;
    pend_addr = '0;
    idle     = 0;

    // Reset values while reset is held low.
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b1;

    // Zero-wait stream: one instruction per cycle, first one right after release.
    for (int k = 1; k <= 5; k++) begin
      cycle();
      chk("stream_valid", 32'(IFID_Valid), 1);
      chk("stream_pc4", IFID_PCPlus4, PC_RESET + 32'(4 * k));
    end

    // Three stall cycles, then the stream resumes with neither gap nor duplicate.
    snap = IFID_PCPlus4;
    Stall = 1'b1;
    repeat (3) cycle();
    Stall = 1'b0;
    cycle();
    chk("resume_valid", 32'(IFID_Valid), 1);
    chk("resume_pc4", IFID_PCPlus4, snap + 32'd4);

    // Branch: one bubble, then the target instruction.
    BranchTaken = 1'b1;
    BranchTarget = 32'h0040_0100;
    cycle();
    clr_redirect();
    chk("br_addr", IMemAddr, 32'h0040_0100);
    chk("br_bubble", 32'(IFID_Valid), 0);
    cycle();
    chk("br_valid", 32'(IFID_Valid), 1);
    chk("br_pc4", IFID_PCPlus4, 32'h0040_0104);

    // Land IFID_PCPlus4 on 0x00400010, then jump and jump+jr.
    BranchTaken = 1'b1;
    BranchTarget = 32'h0040_000D;
    cycle();
    clr_redirect();
    cycle();
    chk("pre_jump_pc4", IFID_PCPlus4, 32'h0040_0010);
    Jump = 1'b1;
    JumpIndex = 26'h0100040;
    cycle();
    clr_redirect();
    chk("jump_addr", IMemAddr, 32'h0040_0100);
    cycle();
    Jump = 1'b1;
    JR = 1'b1;
    JRTarget = 32'h0040_0202;
    cycle();
    clr_redirect();
    chk("jr_addr", IMemAddr, 32'h0040_0200);
    cycle();

    // Ready low four cycles with a branch during the wait.
    IMemReady = 1'b0;
    snap = IMemAddr;
    cycle();
    BranchTaken = 1'b1;
    BranchTarget = 32'h0040_0300;
    cycle();
    clr_redirect();
    repeat (2) begin
      cycle();
      chk("drain_addr", IMemAddr, snap);
      chk("drain_req", 32'(IMemReq), 1);
    end
    IMemReady = 1'b1;
    cycle();
    chk("drain_discard", 32'(IFID_Valid), 0);
    chk("drain_target", IMemAddr, 32'h0040_0300);
    cycle();
    chk("drain_pc4", IFID_PCPlus4, 32'h0040_0304);

    // PC wraps from 0xFFFFFFFC to 0.
    JR = 1'b1;
    JRTarget = 32'hFFFF_FFFC;
    cycle();
    clr_redirect();
    chk("wrap_start", IMemAddr, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_addr", IMemAddr, 32'h0000_0000);
    chk("wrap_pc4", IFID_PCPlus4, 32'h0000_0000);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      int r;
      Stall     = ($urandom_range(0, 3) == 0);
      IMemReady = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 24);
      BranchTaken  = (r == 0) || (r == 3);
      Jump         = (r == 1) || (r == 3) || (r == 4);
      JR           = (r == 2) || (r == 4);
      BranchTarget = $urandom;
      JumpIndex    = 26'($urandom);
      JRTarget     = $urandom;
      cycle();
    end

    // Reset while a request is outstanding: outputs drop without waiting for a clock.
    clr_redirect();
    Stall = 1'b0;
    IMemReady = 1'b1;
    cycle();
    IMemReady = 1'b0;
    #2;
    chk("pre_reset_req", 32'(IMemReq), 1);
    reset = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage and IF/ID pipeline register of the MIPS core. It holds the PC, issues requests to instruction memory over a ready/valid handshake, and selects the next PC from sequential, branch, jump and jump-register sources. Fetched words are registered into IF/ID, whose opcode field drives the control unit directly. The block supports stall from hazard detection and flush on redirect, including a redirect that arrives while a memory request is still pending.

## Interface
- PC_RESET, 32'h0040_0000, PC value loaded at reset (text segment base).
- clk  input  1  core clock, all state on rising edge.
- reset  input  1  asynchronous, active-low; all registers forced to reset values while low.
- Stall  input  1  hold IF/ID contents and PC; no new request issued.
- BranchTaken  input  1  redirect to BranchTarget (single-cycle pulse).
- BranchTarget  input  32  branch destination; bits [1:0] ignored, treated as 00.
- Jump  input  1  redirect to {IFID_PCPlus4[31:28], JumpIndex, 2'b00}.
- JumpIndex  input  26  instr[25:0] of the jump currently in ID.
- JR  input  1  redirect to JRTarget; bits [1:0] ignored.
- JRTarget  input  32  rs value for jr.
- IMemReq  output  1  request valid; reset 0.
- IMemAddr  output  32  word address of request; reset PC_RESET.
- IMemRData  input  32  instruction word, valid when IMemReq & IMemReady.
- IMemReady  input  1  memory accepts/completes request this cycle (may be combinational, zero-wait).
- IFID_Instr  output  32  registered instruction; reset 0 (sll $0 NOP).
- IFID_PCPlus4  output  32  registered PC+4 of IFID_Instr; reset 0.
- IFID_Valid  output  1  IF/ID holds a real instruction; reset 0.
- OP  output  6  IFID_Instr[31:26], to control unit; reset 0.

## Operation
- Redirect priority when several pulse together: JR > Jump > BranchTaken. Any redirect also flushes IF/ID: IFID_Instr<=0, IFID_Valid<=0, IFID_PCPlus4 unchanged. Redirect overrides Stall.
- States: FETCH, HOLD, DRAIN.
- FETCH: IMemReq = !Stall, or 1 if a request is already pending (once raised without Ready, IMemReq and IMemAddr stay constant until Ready). IMemAddr = PC.
  - Req & Ready, no redirect, no Stall: IF/ID <= {IMemRData, PC+4}, Valid<=1, PC<=PC+4.
  - Req & Ready, Stall: word captured into skid register, PC<=PC+4, go HOLD.
  - Req & Ready, redirect: word discarded, PC<=target, stay FETCH.
  - Req & !Ready, redirect: latch target into pending-target register, go DRAIN.
- HOLD: IMemReq=0. When Stall drops, skid word moves to IF/ID, Valid<=1, go FETCH. Redirect in HOLD: skid discarded, PC<=target, go FETCH.
- DRAIN: IMemReq=1 with the old address. On Ready, data is discarded, PC<=pending target, go FETCH. A further redirect in DRAIN overwrites the pending target (latest wins).
- PC+4 and jump arithmetic are 32-bit modulo 2^32: PC 32'hFFFF_FFFC wraps to 0.
- Reset mid-request: IMemReq drops asynchronously and the state returns to FETCH. Memory must tolerate an abandoned request.

## Timing
- Zero-wait memory (Ready tied high): one instruction per cycle. Word at PC appears on IFID_Instr/OP one edge after IMemReq rises.
- Redirect pulse at edge N: the new PC is on IMemAddr after edge N. The first target instruction is in IF/ID after edge N+1, so there is one flush bubble.
- Ready at the first edge after reset release: IFID_Valid=1 after that edge, with IFID_PCPlus4=PC_RESET+4.
- Stall does not insert or lose instructions: the sequence on IFID_Valid-qualified outputs is identical with or without stalls.

## Test plan
- Reset, Ready=1, memory returns addr-based words -> IFID_PCPlus4 = 0x00400004, 0x00400008, … on successive cycles; OP = word[31:26].
- Stall high for 3 cycles mid-stream, with Ready=1 -> IF/ID frozen. After release the next PC+4 follows without a gap or a duplicate.
- BranchTaken with BranchTarget=0x00400100 -> one Valid=0 bubble, then IFID_PCPlus4=0x00400104.
- Jump with JumpIndex=26'h0100040, IFID_PCPlus4=0x00400010 -> next fetch address 0x00400100. JR and Jump together, JRTarget=0x00400200 -> fetch address 0x00400200.
- Ready held low 4 cycles; BranchTaken during the wait -> IMemAddr stays stable until Ready, the returned word never reaches IF/ID, and the next request goes to BranchTarget.
- PC=0xFFFFFFFC, Ready=1 -> next IMemAddr=0x00000000. Assert reset during a pending request -> all outputs go to their reset values immediately.
